// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
//   state_t   : serializer FSM states (IDLE, SHIFT)
//   DEFAULT_* : default word width and FIFO depth
//   cnt_width : width of the per-word bit counter
package piso_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_DEPTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must hold 0..WIDTH (WIDTH is reached only by the parity bit).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_fifo.sv
// Synchronous word FIFO feeding the serializer.
//   clk, rst : clock, asynchronous active-low reset (pointers and level)
//   push     : write wdata (caller guarantees !full)
//   pop      : drop the head word (caller guarantees !empty)
//   wdata    : word to store
//   rdata    : head word, read combinationally from the memory
//   full     : level == DEPTH
//   empty    : level == 0
//   level    : occupancy, 0..DEPTH
module piso_fifo
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    assign rdata = mem[rptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Storage: no reset needed, contents are only read behind a valid level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (a power of two).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: buffers WIDTH-bit words in a FIFO and
// emits each MSB first, one bit per clock, with zero-gap back-to-back words.
// Optional feature macro: PISO_SERIALIZER_PARITY_EN appends an even-parity
// bit (^word) after each word; ser_last then marks the parity bit.
//   clk, rst  : clock, asynchronous active-low reset
//   in_data   : parallel word
//   in_valid  : in_data valid
//   in_ready  : FIFO not full
//   ser_bit   : serial bit to the downstream shift register
//   ser_valid : ser_bit is live (FSM in SHIFT)
//   ser_first : ser_bit is the word MSB
//   ser_last  : ser_bit is the final bit of the word
//   busy      : shifting or FIFO non-empty
//   level     : FIFO occupancy
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     ser_bit,
    output logic                     ser_valid,
    output logic                     ser_first,
    output logic                     ser_last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned CW = cnt_width(WIDTH);

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             load;
    logic             pop;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             par;
`endif

    // No write-through: a full FIFO refuses even when popping this cycle.
    assign in_ready = ~fifo_full;
    assign push     = in_valid & ~fifo_full;
    assign last_bit = (cnt == LAST_CNT);
    assign busy     = (state == SHIFT) | ~fifo_empty;

    piso_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pop/load decision and serial output decode.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        ser_bit   = 1'b0;
        ser_valid = 1'b0;
        ser_first = 1'b0;
        ser_last  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_first = (cnt == '0);
`ifdef PISO_SERIALIZER_PARITY_EN
                ser_bit   = last_bit ? par : sr[WIDTH-1];
`else
                ser_bit   = sr[WIDTH-1];
`endif
                if (last_bit) begin
                    ser_last = 1'b1;
                    // Reload on the last bit so consecutive words have no gap.
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register and bit counter; cnt returns to 0 when a word ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= fifo_rdata;
            cnt <= '0;
        end else if (state == SHIFT) begin
            sr  <= {sr[WIDTH-2:0], 1'b0};
            cnt <= last_bit ? '0 : cnt + CW'(1);
        end
    end

`ifdef PISO_SERIALIZER_PARITY_EN
    // Parity of the word captured when it leaves the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par <= 1'b0;
        end else if (load) begin
            par <= ^fifo_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words are expanded into
// expected serial bits; a negedge monitor pops and compares every live bit.
module tb_piso_serializer;
    import piso_pkg::*;

    localparam int unsigned W  = DEFAULT_WIDTH;
    localparam int unsigned D  = DEFAULT_DEPTH;
    localparam int unsigned LW = $clog2(D) + 1;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int unsigned P = W + (PAR ? 1 : 0);

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ser_bit;
    logic          ser_valid;
    logic          ser_first;
    logic          ser_last;
    logic          busy;
    logic [LW-1:0] level;

    piso_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         b;
        logic         first;
        logic         last;
        logic         par;
        logic [W-1:0] word;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [W-1:0] acc;
    int           bits_seen = 0;
    int           run_len   = 0;
    int           last_run  = 0;
    bit           saw_full  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: WIDTH data bits MSB first, then optional even parity bit.
    task automatic expect_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b     = w[i];
            e.first = (i == W - 1);
            e.last  = (i == 0) && !PAR;
            e.par   = 1'b0;
            e.word  = w;
            sbq.push_back(e);
        end
        if (PAR) begin
            e.b     = ^w;
            e.first = 1'b0;
            e.last  = 1'b1;
            e.par   = 1'b1;
            e.word  = w;
            sbq.push_back(e);
        end
    endtask

    // Called just after a negedge; returns just after the accepting edge's negedge.
    task automatic send(input logic [W-1:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready stayed 0, word %0h not accepted", w);
            in_valid = 1'b0;
        end else begin
            expect_word(w);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        in_valid = 1'b0;
        while ((busy || sbq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy || sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: busy=%0b pending=%0d", busy, sbq.size());
        end
        @(negedge clk);
    endtask

    // Monitor: checks serial bits, handshake rules and downstream word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            acc       = '0;
            bits_seen = 0;
            run_len   = 0;
        end else begin
            check("in_ready_rule", in_ready, level != LW'(D));
            check("busy_rule", busy, ser_valid || (level != '0));
            check("level_bound", level <= LW'(D), 1);
            if (level == LW'(D)) saw_full = 1'b1;
            if (ser_valid) begin
                run_len++;
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_bit: ser_bit=%0b with empty scoreboard at %0t", ser_bit, $time);
                end else begin
                    e = sbq.pop_front();
                    check("ser_bit", ser_bit, e.b);
                    check("ser_first", ser_first, e.first);
                    check("ser_last", ser_last, e.last);
                    if (!e.par) begin
                        acc = {acc[W-2:0], ser_bit};
                        bits_seen++;
                        if (bits_seen == W) begin
                            check("downstream_word", acc, e.word);
                            bits_seen = 0;
                        end
                    end
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_ser_bit", ser_bit, 0);
        check("rst_level", level, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single word with latency check: MSB live one cycle after acceptance.
        send(4'b1011);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_valid", ser_valid, 1);
        check("latency_first", ser_first, 1);
        wait_idle(50);

        // Back-to-back words must stream without gaps.
        send(4'hA);
        send(4'h5);
        send(4'hF);
        wait_idle(50);
        check("b2b_run_len", last_run, 3 * P);

        // Backpressure: continuous valid with six words.
        saw_full = 1'b0;
        send(4'h1);
        send(4'h2);
        send(4'h3);
        send(4'h4);
        send(4'h6);
        send(4'h7);
        wait_idle(100);
        check("bp_full_seen", saw_full, 1);

        // Parity-relevant words (plain data when parity is disabled).
        send(4'b0111);
        send(4'b0110);
        wait_idle(50);

        // Random traffic with random idle gaps.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send(W'($urandom));
        end
        wait_idle(400);

        // Reset after two bits of 4'hC with more words queued.
        send(4'hC);
        send(4'h9);
        send(4'h6);
        in_valid = 1'b0;
        n = 0;
        while (bits_seen != 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pre_reset_bits", bits_seen, 2);
        rst = 1'b0;
        sbq.delete();
        #1;
        check("mid_rst_ser_valid", ser_valid, 0);
        check("mid_rst_ser_first", ser_first, 0);
        check("mid_rst_ser_last", ser_last, 0);
        check("mid_rst_ser_bit", ser_bit, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(4'h3);
        wait_idle(50);

        check("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
